// File: rtl/matmul_out_collector.sv
// Deskew/writeback stage for the systolic array bottom edge: reassembles column-skewed
// result words into rows and writes one row per cycle to the output BRAM. Optional macro: PROXY_SUBST_EN.
module matmul_out_collector #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int WORD_SIZE      = 16,
   parameter int MEM_PORT_WIDTH = COLS*WORD_SIZE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [31:0]               base_addr,
   input  logic [COLS-1:0]           col_valid,
   input  logic [COLS*WORD_SIZE-1:0] col_data,
`ifdef PROXY_SUBST_EN
   input  logic [COLS-1:0]           proxy_out_valid_bus,
   input  logic [COLS*WORD_SIZE-1:0] proxy_output_bus,
   input  logic [COLS-1:0]           faulty_col_mask,
`endif
   output logic [MEM_PORT_WIDTH-1:0] output_mem_wr_data,
   output logic [31:0]               output_mem_addr,
   output logic                      output_mem_wr_en,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow_err
);

   localparam int CW = $clog2(ROWS + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             rcnt_q [COLS];
   logic [CW-1:0]             rcnt_d [COLS];
   logic [CW-1:0]             wcnt_q, wcnt_d;
   logic [CW-1:0]             minRcnt;
   logic [WORD_SIZE-1:0]      rowBuf_q [ROWS][COLS];
   logic [WORD_SIZE-1:0]      rowBuf_d [ROWS][COLS];
   logic [31:0]               addrBase_q, addrBase_d;
   logic                      overflow_q, overflow_d;
   logic                      wrEn_q, wrEn_d;
   logic [31:0]               wrAddr_q, wrAddr_d;
   logic [MEM_PORT_WIDTH-1:0] wrData_q, wrData_d;
   logic [COLS-1:0]           effValid;
   logic [COLS*WORD_SIZE-1:0] effData;
`ifdef PROXY_SUBST_EN
   logic [COLS-1:0]           faultyMask_q, faultyMask_d;
`endif

   // Masked columns take their stream from the proxy bus instead of the array edge
   always_comb begin
      effValid = col_valid;
      effData  = col_data;
`ifdef PROXY_SUBST_EN
      for (int c = 0; c < COLS; c++) begin
         if (faultyMask_q[c]) begin
            effValid[c]                         = proxy_out_valid_bus[c];
            effData[c*WORD_SIZE +: WORD_SIZE]   = proxy_output_bus[c*WORD_SIZE +: WORD_SIZE];
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (wcnt_q == ROWS_C) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy               = (state_q == COLLECT);
      done               = (state_q == DONE);
      output_mem_wr_en   = wrEn_q;
      output_mem_addr    = wrAddr_q;
      output_mem_wr_data = wrData_q;
      overflow_err       = overflow_q;
   end

   // Writeback looks at the post-capture counters and buffer so a row leaves
   // on the same edge that captures its final word
   always_comb begin
      rcnt_d     = rcnt_q;
      wcnt_d     = wcnt_q;
      rowBuf_d   = rowBuf_q;
      addrBase_d = addrBase_q;
      overflow_d = overflow_q;
      wrEn_d     = 1'b0;
      wrAddr_d   = wrAddr_q;
      wrData_d   = wrData_q;
      minRcnt    = ROWS_C;
`ifdef PROXY_SUBST_EN
      faultyMask_d = faultyMask_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               addrBase_d = base_addr;
               wcnt_d     = '0;
               overflow_d = 1'b0;
               for (int c = 0; c < COLS; c++) rcnt_d[c] = '0;
`ifdef PROXY_SUBST_EN
               faultyMask_d = faulty_col_mask;
`endif
            end
            if (|effValid) overflow_d = 1'b1;
         end
         COLLECT: begin
            for (int c = 0; c < COLS; c++) begin
               if (effValid[c]) begin
                  if (rcnt_q[c] < ROWS_C) begin
                     rowBuf_d[rcnt_q[c][RW-1:0]][c] = effData[c*WORD_SIZE +: WORD_SIZE];
                     rcnt_d[c] = rcnt_q[c] + CW'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
            for (int c = 0; c < COLS; c++) begin
               if (rcnt_d[c] < minRcnt) minRcnt = rcnt_d[c];
            end
            if (wcnt_q < minRcnt) begin
               wrEn_d   = 1'b1;
               wrAddr_d = addrBase_q + 32'(wcnt_q);
               wrData_d = '0;
               for (int c = 0; c < COLS; c++) begin
                  wrData_d[c*WORD_SIZE +: WORD_SIZE] = rowBuf_d[wcnt_q[RW-1:0]][c];
               end
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         DONE: begin
            if (|effValid) overflow_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < COLS; c++) rcnt_q[c] <= '0;
         wcnt_q     <= '0;
         addrBase_q <= '0;
         overflow_q <= 1'b0;
         wrEn_q     <= 1'b0;
         wrAddr_q   <= '0;
         wrData_q   <= '0;
`ifdef PROXY_SUBST_EN
         faultyMask_q <= '0;
`endif
      end else begin
         rcnt_q     <= rcnt_d;
         wcnt_q     <= wcnt_d;
         addrBase_q <= addrBase_d;
         overflow_q <= overflow_d;
         wrEn_q     <= wrEn_d;
         wrAddr_q   <= wrAddr_d;
         wrData_q   <= wrData_d;
`ifdef PROXY_SUBST_EN
         faultyMask_q <= faultyMask_d;
`endif
      end
   end

   // Row storage needs no reset; counters gate every read
   always_ff @(posedge clk) begin
      rowBuf_q <= rowBuf_d;
   end

endmodule

// File: tb/tb_matmul_out_collector.sv
// Randomized scoreboard bench for matmul_out_collector: a row-level model predicts every
// write (cycle, address, packed data) and the done pulse; a monitor compares as outputs appear.
module tb_matmul_out_collector;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int W    = 16;
   localparam int MW   = COLS*W;

   typedef logic [W-1:0] mat_t [ROWS][COLS];
   typedef struct {
      int           cycle;
      logic [31:0]  addr;
      logic [MW-1:0] data;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [31:0]     base_addr;
   logic [COLS-1:0] col_valid;
   logic [MW-1:0]   col_data;
   logic [COLS-1:0] proxyValid;
   logic [MW-1:0]   proxyData;
   logic [COLS-1:0] faultyMask;
   logic [MW-1:0]   output_mem_wr_data;
   logic [31:0]     output_mem_addr;
   logic            output_mem_wr_en;
   logic            busy;
   logic            done;
   logic            overflow_err;

   matmul_out_collector #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .MEM_PORT_WIDTH(MW)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .base_addr          (base_addr),
      .col_valid          (col_valid),
      .col_data           (col_data),
`ifdef PROXY_SUBST_EN
      .proxy_out_valid_bus(proxyValid),
      .proxy_output_bus   (proxyData),
      .faulty_col_mask    (faultyMask),
`endif
      .output_mem_wr_data (output_mem_wr_data),
      .output_mem_addr    (output_mem_addr),
      .output_mem_wr_en   (output_mem_wr_en),
      .busy               (busy),
      .done               (done),
      .overflow_err       (overflow_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wr_t wrQ[$];
   int  doneQ[$];
   int  compared   = 0;
   int  mismatched = 0;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every write and every done pulse must match the head of its queue
   initial begin : monitor
      wr_t e;
      int  d;
      forever begin
         @(negedge clk);
         if (output_mem_wr_en === 1'b1) begin
            if (wrQ.size() == 0) begin
               checkOutput("unexpectedWrite", output_mem_addr, 128'hDEAD);
            end else begin
               e = wrQ.pop_front();
               checkOutput("wrCycle", cyc, e.cycle);
               checkOutput("wrAddr", output_mem_addr, e.addr);
               checkOutput("wrData", output_mem_wr_data, e.data);
            end
         end
         if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
               checkOutput("unexpectedDone", 1, 0);
            end else begin
               d = doneQ.pop_front();
               checkOutput("doneCycle", cyc, d);
               checkOutput("busyInDone", busy, 0);
            end
         end
      end
   end

   // mode 0: skewed, 1: column 0 first, 2: random gaps, 3: skewed plus col_valid with start
   task automatic applyStimulus(input logic [31:0] base, input mat_t m, input int mode,
                                input int extraCol, input int rstSlot, input logic [COLS-1:0] pmask);
      int  arr [COLS][ROWS];
      int  wExp [ROWS];
      int  maxSlot, cyc0, capLast;
      wr_t e;
      logic expOvf;
      maxSlot = 0;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            case (mode)
               1:       arr[c][r] = (c == 0) ? 1 + r : 6 + r + c - 1;
               2:       arr[c][r] = ((r == 0) ? 0 : arr[c][r-1]) + int'($urandom_range(1, 3));
               default: arr[c][r] = 1 + r + c;
            endcase
            if (arr[c][r] > maxSlot) maxSlot = arr[c][r];
         end
      end
      maxSlot += 2;
      expOvf = (extraCol >= 0) || (mode == 3);

      @(posedge clk); #1;
      start      = 1'b1;
      base_addr  = base;
      faultyMask = pmask;
      if (mode == 3) begin
         col_valid = 4'b0001;
         col_data  = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      start     = 1'b0;
      col_valid = '0;
      cyc0      = cyc;
      checkOutput("busyCollect", busy, 1);

      // Row r can leave one cycle after its latest column word, in order, one per cycle
      for (int r = 0; r < ROWS; r++) begin
         capLast = 0;
         for (int c = 0; c < COLS; c++) if (arr[c][r] > capLast) capLast = arr[c][r];
         wExp[r] = cyc0 + capLast;
         if (r > 0 && wExp[r] <= wExp[r-1]) wExp[r] = wExp[r-1] + 1;
         if (rstSlot == 0 || wExp[r] <= cyc0 + rstSlot - 1) begin
            e.cycle = wExp[r];
            e.addr  = base + 32'(r);
            for (int c = 0; c < COLS; c++) e.data[c*W +: W] = m[r][c];
            wrQ.push_back(e);
         end
      end
      if (rstSlot == 0) doneQ.push_back(wExp[ROWS-1] + 1);

      for (int t = 1; t <= maxSlot; t++) begin
         if (rstSlot != 0 && t == rstSlot) rst = 1'b1;
         col_valid  = '0;
         col_data   = {$urandom, $urandom};
         proxyValid = '0;
         proxyData  = {$urandom, $urandom};
         for (int c = 0; c < COLS; c++) begin
            if (pmask[c]) col_valid[c] = 1'($urandom);
            for (int r = 0; r < ROWS; r++) begin
               if (arr[c][r] == t) begin
                  if (pmask[c]) begin
                     proxyValid[c]       = 1'b1;
                     proxyData[c*W +: W] = m[r][c];
                  end else begin
                     col_valid[c]       = 1'b1;
                     col_data[c*W +: W] = m[r][c];
                  end
               end
            end
         end
         if (extraCol >= 0 && t == arr[extraCol][ROWS-1] + 1) col_valid[extraCol] = 1'b1;
         @(posedge clk); #1;
         if (rstSlot != 0 && t == rstSlot) begin
            checkOutput("rstOutputs", {output_mem_wr_en, output_mem_addr, output_mem_wr_data,
                                       busy, done, overflow_err}, 0);
            rst       = 1'b0;
            col_valid = '0;
            break;
         end
      end
      col_valid  = '0;
      proxyValid = '0;

      for (int i = 0; i < 40 && (wrQ.size() != 0 || doneQ.size() != 0); i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("drainQueues", wrQ.size() + doneQ.size(), 0);
      checkOutput("overflowErr", overflow_err, rstSlot != 0 ? 1'b0 : expOvf);
      wrQ.delete();
      doneQ.delete();
   endtask

   mat_t nom;
   mat_t rnd;

   initial begin
      nom = '{'{16'd67, 16'd43,  16'd81,  16'd23},
              '{16'd85, 16'd101, 16'd173, 16'd38},
              '{16'd80, 16'd114, 16'd232, 16'd43},
              '{16'd71, 16'd94,  16'd220, 16'd37}};
      rst = 1'b1; start = 1'b0; base_addr = '0; col_valid = '0; col_data = '0;
      proxyValid = '0; proxyData = '0; faultyMask = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetOutputs", {output_mem_wr_en, output_mem_addr, output_mem_wr_data,
                                   busy, done, overflow_err}, 0);
      rst = 1'b0;

      $display("[TB] nominal skewed stream");
      applyStimulus(32'h10, nom, 0, -1, 0, '0);
      $display("[TB] column 0 first");
      applyStimulus(32'h20, nom, 1, -1, 0, '0);
      $display("[TB] extra word on column 2");
      applyStimulus(32'h30, nom, 0, 2, 0, '0);
      $display("[TB] col_valid with start");
      applyStimulus(32'h50, nom, 3, -1, 0, '0);
      $display("[TB] reset after two rows");
      applyStimulus(32'h40, nom, 0, -1, 6, '0);
      $display("[TB] restart after reset");
      applyStimulus(32'h10, nom, 0, -1, 0, '0);
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) rnd[r][c] = W'($urandom);
         $display("[TB] random matmul %0d", k);
         applyStimulus($urandom, rnd, 2, (k == 3) ? 1 : -1, 0, '0);
      end
`ifdef PROXY_SUBST_EN
      $display("[TB] proxy substitution on column 2");
      applyStimulus(32'h60, nom, 0, -1, 0, 4'b0100);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
